// File: rtl/roi_scan_seq.sv
// Serial scan sequencer for the BRAM minitest harness: shifts a command word into
// the ROI input chain, strobes it in, re-strobes to capture the ROI output, shifts it back.
module roi_scan_seq #(
    parameter int N     = 256,
    parameter int CNT_W = $clog2(3*N+2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_word,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_word,
    output logic         busy,
    output logic         di,
    output logic         stb,
    input  logic         do_in
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_LOAD      = 3'd2,
        S_SETTLE    = 3'd3,
        S_CAPTURE   = 3'd4,
        S_SHIFT_OUT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_SI_END = CNT_W'(N-1);
    localparam logic [CNT_W-1:0] C_SE_END = CNT_W'(2*N-1);
    localparam logic [CNT_W-1:0] C_SO_END = CNT_W'(3*N);

    function automatic logic [N-1:0] rotl1(input logic [N-1:0] w);
        return {w[N-2:0], w[N-1]};
    endfunction

    state_t         state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [N-1:0]   wreg_r, wreg_nxt_s;
    logic [N-1:0]   rsp_sh_r, rsp_sh_nxt_s;
    logic           accept_s, handoff_s, busy_nxt_s;
    logic           cmd_ready_nxt_s, rsp_valid_nxt_s, di_nxt_s, stb_nxt_s;
    logic [N-1:0]   rsp_word_nxt_s;

    assign accept_s  = (state_r == S_IDLE) && cmd_valid && cmd_ready;
    assign handoff_s = (state_r == S_DONE) && rsp_valid && rsp_ready;

    // State register plus datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            wreg_r    <= '0;
            rsp_sh_r  <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_word  <= '0;
            busy      <= 1'b0;
            di        <= 1'b0;
            stb       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            wreg_r    <= wreg_nxt_s;
            rsp_sh_r  <= rsp_sh_nxt_s;
            cmd_ready <= cmd_ready_nxt_s;
            rsp_valid <= rsp_valid_nxt_s;
            rsp_word  <= rsp_word_nxt_s;
            busy      <= busy_nxt_s;
            di        <= di_nxt_s;
            stb       <= stb_nxt_s;
        end
    end

    // Next-state and cycle-counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        case (state_r)
            S_IDLE: begin
                cnt_nxt_s = '0;
                if (accept_s) state_nxt_s = S_SHIFT_IN;
                else          state_nxt_s = S_IDLE;
            end
            S_SHIFT_IN: begin
                if (cnt_r == C_SI_END) state_nxt_s = S_LOAD;
                else                   state_nxt_s = S_SHIFT_IN;
            end
            S_LOAD:    state_nxt_s = S_SETTLE;
            S_SETTLE: begin
                if (cnt_r == C_SE_END) state_nxt_s = S_CAPTURE;
                else                   state_nxt_s = S_SETTLE;
            end
            S_CAPTURE: state_nxt_s = S_SHIFT_OUT;
            S_SHIFT_OUT: begin
                if (cnt_r == C_SO_END) state_nxt_s = S_DONE;
                else                   state_nxt_s = S_SHIFT_OUT;
            end
            S_DONE: begin
                if (handoff_s) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = S_DONE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; the word rotates so di recirculates MSB first
    always_comb begin
        busy_nxt_s      = (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
        cmd_ready_nxt_s = (state_nxt_s == S_IDLE);
        stb_nxt_s       = (state_nxt_s == S_LOAD) || (state_nxt_s == S_CAPTURE);
        rsp_valid_nxt_s = (state_r == S_DONE) && !handoff_s;
        rsp_word_nxt_s  = rsp_word;
        rsp_sh_nxt_s    = rsp_sh_r;
        wreg_nxt_s      = wreg_r;
        di_nxt_s        = 1'b0;
        if (accept_s) begin
            wreg_nxt_s = rotl1(cmd_word);
            di_nxt_s   = cmd_word[N-1];
        end else if (busy_nxt_s) begin
            wreg_nxt_s = rotl1(wreg_r);
            di_nxt_s   = wreg_r[N-1];
        end else begin
            wreg_nxt_s = wreg_r;
            di_nxt_s   = 1'b0;
        end
        if (state_r == S_SHIFT_OUT) rsp_sh_nxt_s = {rsp_sh_r[N-2:0], do_in};
        else                        rsp_sh_nxt_s = rsp_sh_r;
        if ((state_r == S_DONE) && !rsp_valid) rsp_word_nxt_s = rsp_sh_r;
        else                                   rsp_word_nxt_s = rsp_word;
    end

endmodule
